// File: rtl/alu_seq_unit_if.sv
// Operand/result handshake bundle for alu_seq_unit.
// The producer (register-read side) and the consumer (writeback side) share one bundle.
interface alu_seq_unit_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ALU_ctrl;
  logic [XLEN-1:0] data_in_A;
  logic [XLEN-1:0] data_in_B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] data_out;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, ALU_ctrl, data_in_A, data_in_B, out_ready,
    input  in_ready, out_valid, data_out, zero, illegal
  );

  modport slave (
    input  in_valid, ALU_ctrl, data_in_A, data_in_B, out_ready,
    output in_ready, out_valid, data_out, zero, illegal
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Parametrised ALU with 11 ops, registered result/flags and a radix-2 iterative multiplier.
// Single-cycle ops complete on the accept edge; MUL takes XLEN further cycles in BUSY.
module alu_seq_unit #(
  parameter int unsigned XLEN = 64
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_unit_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSltu = 4'd6;
  localparam logic [3:0] OpSll  = 4'd7;
  localparam logic [3:0] OpSrl  = 4'd8;
  localparam logic [3:0] OpSra  = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [XLEN-1:0] acc_sum;

  // in_ready depends only on state and out_ready, never on in_valid
  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign bus.out_valid = (state_q == StDone);
  assign bus.data_out  = data_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign shamt   = bus.data_in_B[SHW-1:0];
  // Partial product for the current multiplier bit
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle op decode; unassigned codes give 0 and flag illegal
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.ALU_ctrl)
      OpAnd:   alu_res = bus.data_in_A & bus.data_in_B;
      OpOr:    alu_res = bus.data_in_A | bus.data_in_B;
      OpAdd:   alu_res = bus.data_in_A + bus.data_in_B;
      OpSub:   alu_res = bus.data_in_A - bus.data_in_B;
      OpXor:   alu_res = bus.data_in_A ^ bus.data_in_B;
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.data_in_A) < $signed(bus.data_in_B)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, bus.data_in_A < bus.data_in_B};
      OpSll:   alu_res = bus.data_in_A << shamt;
      OpSrl:   alu_res = bus.data_in_A >> shamt;
      OpSra:   alu_res = $signed(bus.data_in_A) >>> shamt;
      OpMul:   alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state and datapath updates for IDLE/BUSY/DONE
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (bus.ALU_ctrl == OpMul) begin
            mcand_d  = bus.data_in_A;
            mplier_d = bus.data_in_B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StBusy;
          end else begin
            data_d    = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = StDone;
          end
        end else if ((state_q == StDone) && bus.out_ready) begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN - 1)) begin
          data_d    = acc_sum;
          zero_d    = (acc_sum == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: XLEN=64 and XLEN=32 instances, directed and random ops.
module tb_alu_seq_unit;
  typedef struct {
    logic [63:0] data;
    logic        z;
    logic        il;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q64[$];
  exp_t        q32[$];
  logic        seen64 = 1'b0;
  logic        seen32 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_unit_if #(.XLEN(64)) b64 ();
  alu_seq_unit_if #(.XLEN(32)) b32 ();

  alu_seq_unit #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  alu_seq_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on w-bit values held in 64-bit containers
  function automatic exp_t model(input int unsigned w, input logic [3:0] c,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t        e;
    logic [63:0] mask, a, b, r;
    longint      sa, sb;
    int unsigned sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = a[w-1] ? $signed(a | ~mask) : $signed(a);
    sb   = b[w-1] ? $signed(b | ~mask) : $signed(b);
    sh   = int'(b % 64'(w));
    e.il = 1'b0;
    e.lat = 1;
    case (c)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd3:    r = a - b;
      4'd4:    r = a ^ b;
      4'd5:    r = (sa < sb) ? 64'd1 : 64'd0;
      4'd6:    r = (a < b) ? 64'd1 : 64'd0;
      4'd7:    r = a << sh;
      4'd8:    r = a >> sh;
      4'd9:    r = 64'(sa >>> sh);
      4'd10: begin
        r = a * b;
        e.lat = w + 1;
      end
      default: begin
        r = 64'd0;
        e.il = 1'b1;
      end
    endcase
    e.data = r & mask;
    e.z    = (e.data == 64'd0);
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic cmp_result(input string tag, input exp_t e, input logic [63:0] d,
                            input logic z, input logic il);
    check({tag, " data"}, d, e.data);
    check({tag, " zero"}, {63'd0, z}, {63'd0, e.z});
    check({tag, " illegal"}, {63'd0, il}, {63'd0, e.il});
    check({tag, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
  endtask

  // Monitors: compare each newly presented result against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) seen64 <= 1'b0;
    else if (b64.out_valid) begin
      if (!seen64) begin
        if (q64.size() == 0) check("x64 unexpected result", 64'd1, 64'd0);
        else begin
          e = q64.pop_front();
          cmp_result("x64", e, b64.data_out, b64.zero, b64.illegal);
        end
      end
      seen64 <= !b64.out_ready;
    end else seen64 <= 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) seen32 <= 1'b0;
    else if (b32.out_valid) begin
      if (!seen32) begin
        if (q32.size() == 0) check("x32 unexpected result", 64'd1, 64'd0);
        else begin
          e = q32.pop_front();
          cmp_result("x32", e, {32'd0, b32.data_out}, b32.zero, b32.illegal);
        end
      end
      seen32 <= !b32.out_ready;
    end else seen32 <= 1'b0;
  end

  // Present an op (called at posedge+1), wait for in_ready, push expectation, deassert
  task automatic issue(input bit w32, input logic [3:0] c, input logic [63:0] a,
                       input logic [63:0] b, output int waits);
    exp_t e;
    bit   rdy;
    e = model(w32 ? 32 : 64, c, a, b);
    if (w32) begin
      b32.in_valid = 1'b1; b32.ALU_ctrl = c; b32.data_in_A = a[31:0]; b32.data_in_B = b[31:0];
    end else begin
      b64.in_valid = 1'b1; b64.ALU_ctrl = c; b64.data_in_A = a; b64.data_in_B = b;
    end
    waits = 0;
    rdy = 1'b0;
    while (!rdy && waits <= 200) begin
      @(negedge clk);
      rdy = w32 ? b32.in_ready : b64.in_ready;
      if (!rdy) begin
        waits++;
        @(posedge clk);
        #1;
        if (w32) b32.out_ready = 1'b1;
        else b64.out_ready = 1'b1;
      end
    end
    if (!rdy) begin
      check("issue in_ready timeout", 64'd0, 64'd1);
    end else begin
      e.acc = cyc;
      if (w32) q32.push_back(e);
      else q64.push_back(e);
      @(posedge clk);
      #1;
    end
    b64.in_valid = 1'b0;
    b32.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    b64.out_ready = 1'b1;
    b32.out_ready = 1'b1;
    while ((q64.size() != 0 || q32.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain queues empty", 64'(q64.size() + q32.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int bad;
    b64.in_valid = 1'b0; b64.ALU_ctrl = 4'd0; b64.data_in_A = '0; b64.data_in_B = '0;
    b64.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.ALU_ctrl = 4'd0; b32.data_in_A = '0; b32.data_in_B = '0;
    b32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {63'd0, b64.out_valid}, 64'd0);
    check("reset in_ready", {63'd0, b64.in_ready}, 64'd1);
    check("reset data_out", b64.data_out, 64'd0);
    check("reset zero", {63'd0, b64.zero}, 64'd0);
    check("reset illegal", {63'd0, b64.illegal}, 64'd0);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops, one per cycle
    issue(0, 4'd2, 64'd5, -64'sd7, w);
    issue(0, 4'd3, 64'd3, 64'd3, w);
    check("b2b SUB wait", 64'(w), 64'd0);
    issue(0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, w);
    check("b2b XOR wait", 64'(w), 64'd0);
    issue(0, 4'd9, 64'h8000_0000_0000_0000, 64'h41, w);
    issue(0, 4'd7, 64'd1, 64'd63, w);
    issue(0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, w);
    issue(0, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, w);
    drain();

    // MUL with in_valid pulses during BUSY
    issue(0, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, w);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      b64.in_valid = 1'b1;
      b64.ALU_ctrl = 4'd2;
      b64.data_in_A = {$urandom, $urandom};
      @(negedge clk);
      if (b64.in_ready || b64.out_valid) bad++;
      @(posedge clk);
      #1;
    end
    b64.in_valid = 1'b0;
    check("busy in_ready/out_valid low cycles", 64'(bad), 64'd0);
    drain();

    // Backpressure hold, then hand-off with a new accept on the same edge
    b64.out_ready = 1'b0;
    issue(0, 4'd2, 64'd1, 64'd1, w);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b64.data_out !== 64'd2 || !b64.out_valid || b64.in_ready) bad++;
      @(posedge clk);
      #1;
    end
    check("backpressure hold cycles", 64'(bad), 64'd0);
    b64.out_ready = 1'b1;
    issue(0, 4'd3, 64'd9, 64'd4, w);
    check("hand-off wait", 64'(w), 64'd0);

    // Illegal op then a legal op clears the flag
    issue(0, 4'b1100, {$urandom, $urandom}, {$urandom, $urandom}, w);
    issue(0, 4'd0, 64'hF0F0, 64'h0FF0, w);
    drain();

    // Randomised ops with random backpressure
    for (int i = 0; i < 150; i++) begin
      b64.out_ready = ($urandom_range(0, 3) != 0);
      issue(0, 4'($urandom_range(0, 15)), pick(), pick(), w);
    end
    drain();

    // Reset in the middle of a MUL
    issue(0, 4'd10, {$urandom, $urandom}, {$urandom, $urandom}, w);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q64.delete();
    check("mid-MUL reset out_valid", {63'd0, b64.out_valid}, 64'd0);
    check("mid-MUL reset in_ready", {63'd0, b64.in_ready}, 64'd1);
    check("mid-MUL reset data_out", b64.data_out, 64'd0);
    check("mid-MUL reset flags", {62'd0, b64.zero, b64.illegal}, 64'd0);
    issue(0, 4'd2, 64'd2, 64'd2, w);
    drain();

    // XLEN=32 wrap and latency
    issue(1, 4'd2, 64'hFFFF_FFFF, 64'd1, w);
    issue(1, 4'd3, 64'd0, 64'd1, w);
    issue(1, 4'd10, 64'h1_0000, 64'h1_0000, w);
    issue(1, 4'd10, 64'hFFFF_FFFF, 64'd3, w);
    issue(1, 4'd9, 64'h8000_0000, 64'h21, w);
    for (int i = 0; i < 60; i++) begin
      b32.out_ready = ($urandom_range(0, 3) != 0);
      issue(1, 4'($urandom_range(0, 15)), pick(), pick(), w);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Parametrised successor to the combinational 64-bit datapath ALU. It widens the op set to 11 operations, parametrises the word width, and adds a multi-cycle iterative multiplier. It sits between register-read and writeback. A valid/ready handshake on both sides lets the control FSM stall on multi-cycle ops. Results and the zero flag are registered.

Parameters:
XLEN, 64, operand/result width in bits; power of two, 8..64.
SHW, $clog2(XLEN), shift-amount width; derived, do not override.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands and op are valid
in_ready  out  1  unit can accept an op this cycle
ALU_ctrl  in  4  operation select; encoding under Behaviour
data_in_A  in  XLEN  operand A, signed two's complement
data_in_B  in  XLEN  operand B, signed two's complement
out_valid  out  1  data_out, zero and illegal hold a result
out_ready  in  1  consumer takes the result this cycle
data_out  out  XLEN  registered result
zero  out  1  registered; 1 iff data_out == 0
illegal  out  1  registered; 1 iff the op code was unassigned

Behaviour:
- Reset: rst_n sampled low at a clk edge forces the following, overriding all other inputs that cycle, including mid-MUL:
  - state=IDLE, out_valid=0, data_out=0, zero=0, illegal=0, iteration counter=0.
  - Any in-flight MUL is discarded.
- Op encoding. Legacy 2-bit codes are preserved in the low bits.
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR.
  - 0101 SLT: signed A<B, result 1 or 0.
  - 0110 SLTU: unsigned A<B, result 1 or 0.
  - 0111 SLL, 1000 SRL, 1001 SRA: shift amount = B[SHW-1:0]; upper bits of B ignored.
  - 1010 MUL: low XLEN bits of A*B; sign-agnostic.
  - 1011-1111: illegal; result 0, illegal=1, zero=1.
- ADD, SUB and MUL wrap modulo 2^XLEN; no overflow flag.
- Accept: an op is accepted on an edge where in_valid && in_ready. ALU_ctrl, A and B are sampled only on that edge; they are don't-care otherwise.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accepting a single-cycle or illegal op: result registered on the same edge; next state DONE. Latency 1 cycle.
  - IDLE, accepting MUL: latch A, B; clear accumulator; counter=0; next state BUSY.
  - BUSY: radix-2 shift-add, one multiplier bit per cycle, counter increments each cycle. When counter == XLEN-1, register the result and go to DONE. MUL latency is XLEN+1 cycles from the accept edge to out_valid.
  - DONE: out_valid=1. When out_ready=1: if a new op is accepted the same edge, behave as the IDLE accept; otherwise go to IDLE and out_valid falls. When out_ready=0: hold data_out, zero and illegal stable.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only; no path from in_valid.
- Throughput: single-cycle ops sustain 1 op/cycle while out_ready stays high.
- BUSY ignores in_valid: in_ready=0, no op is accepted.
- out_valid is set only in DONE; it is never 1 in IDLE or BUSY.
- zero and illegal update only with data_out.

Test Plan:
- XLEN=64, back-to-back, out_ready=1: ADD 5+(-7), then SUB 3-3, then XOR all-ones^all-ones -> one result per cycle: 0xFFFF_FFFF_FFFF_FFFE (zero=0), then 0 (zero=1), then 0 (zero=1); in_ready never drops.
- Shifts and compares: SRA 0x8000_0000_0000_0000 by B=0x41 -> shift 1, result 0xC000_0000_0000_0000. SLL 1 by 63 -> 0x8000_0000_0000_0000. SLT(-1,1)=1. SLTU(-1,1)=0.
- MUL 0xFFFF_FFFF_FFFF_FFFF * 3 -> 0xFFFF_FFFF_FFFF_FFFD.
  - out_valid rises exactly 65 cycles after the accept edge.
  - in_ready=0 throughout BUSY; in_valid pulses during BUSY are not accepted.
- Backpressure: hold out_ready=0 for 10 cycles after ADD 1+1 -> data_out stays 2, out_valid stays 1, in_ready=0. Raise out_ready with a new op -> hand-off and new accept on the same edge.
- Illegal op 1100 -> data_out=0, zero=1, illegal=1, latency 1. The next legal op clears illegal.
- rst_n low for one edge at MUL iteration 30 -> next cycle state IDLE, out_valid=0, in_ready=1, outputs 0. A following ADD 2+2 returns 4 with latency 1.
- Repeat the ADD/MUL wrap checks at XLEN=32, including MUL 0x1_0000 * 0x1_0000 -> 0 and latency 33.
